pc_unit_rstack: RTL

//  Parametrised program-counter unit for the SLC-3 datapath. Holds the PC register,

---
 rtl/pc_unit_rstack_if.sv | 39 +++
 rtl/pc_unit_rstack.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pc_unit_rstack_if.sv
// Bus bundle for the SLC-3 program-counter unit with return-address stack.
// master : datapath/control side, drives load/select/stack controls, observes PC and stack status.
// slave  : the PC unit itself.
// Signals:
//   LD_PC, PCMUX, pc_bus, pc_adder   PC load enable, next-PC select and the two external sources
//   push, pop, clr_err               return-stack controls and sticky-error clear
//   PC                               current program counter
//   ras_count, ras_empty, ras_full   return-stack occupancy
//   ras_ovf, ras_unf                 sticky overflow / underflow flags
interface pc_unit_rstack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             LD_PC;
    logic [1:0]       PCMUX;
    logic [WIDTH-1:0] pc_bus;
    logic [WIDTH-1:0] pc_adder;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] PC;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output LD_PC, PCMUX, pc_bus, pc_adder, push, pop, clr_err,
        input  PC, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  LD_PC, PCMUX, pc_bus, pc_adder, push, pop, clr_err,
        output PC, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_unit_rstack.sv
// Program-counter unit for the SLC-3 datapath with a hardware return-address stack.
// Holds PC, selects the next PC (PC+1 / bus / address adder / stack top) and keeps a
// DEPTH-entry LIFO of return addresses for JSR/JSRR/RET.
// Ports:
//   Clk    rising-edge clock for all state
//   Reset  synchronous, active-high; dominates every other input
//   bus    pc_unit_rstack_if.slave (controls in, PC and stack status out)
module pc_unit_rstack #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                Clk,
    input  logic                Reset,
    pc_unit_rstack_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] SEL_INC   = 2'b00;
    localparam logic [1:0] SEL_BUS   = 2'b01;
    localparam logic [1:0] SEL_ADDER = 2'b10;
    localparam logic [1:0] SEL_RAS   = 2'b11;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] ras_mem_q [DEPTH];

    logic             ras_empty_w;
    logic             ras_full_w;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] top_val;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             ovf_set;
    logic             unf_set;

    // Occupancy decode from the registered count.
    assign ras_empty_w = (cnt_q == '0);
    assign ras_full_w  = (cnt_q == CW'(DEPTH));

    // Top-of-stack as held before the edge; meaningless when empty and never used then.
    assign top_idx = AW'(cnt_q - CW'(1));
    assign top_val = ras_mem_q[top_idx];

    // Next-state for PC, stack pointer and sticky flags.
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = AW'(cnt_q);
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (bus.LD_PC) begin
            unique case (bus.PCMUX)
                SEL_INC:   pc_d = pc_q + WIDTH'(1);
                SEL_BUS:   pc_d = bus.pc_bus;
                SEL_ADDER: pc_d = bus.pc_adder;
                SEL_RAS: begin
                    // An empty stack has no valid top: hold PC rather than load stale data.
                    if (!ras_empty_w) begin
                        pc_d = top_val;
                    end
                end
                default:   pc_d = pc_q;
            endcase
        end

        if (bus.push && bus.pop) begin
            if (ras_empty_w) begin
                // Nothing to pop: the push still happens and the underflow is recorded.
                wr_en   = 1'b1;
                wr_idx  = '0;
                cnt_d   = CW'(1);
                unf_set = 1'b1;
            end else begin
                // Swap: overwrite the top in place; count unchanged, no overflow even when full.
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
        end else if (bus.push) begin
            if (ras_full_w) begin
                ovf_set = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_idx = AW'(cnt_q);
                cnt_d  = cnt_q + CW'(1);
            end
        end else if (bus.pop) begin
            if (ras_empty_w) begin
                unf_set = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // A new error in the same cycle as a clear wins.
        ovf_d = (ovf_q & ~bus.clr_err) | ovf_set;
        unf_d = (unf_q & ~bus.clr_err) | unf_set;

        if (Reset) begin
            wr_en = 1'b0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; contents are don't-care after reset so it has no reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            ras_mem_q[wr_idx] <= pc_q;
        end
    end

    assign bus.PC        = pc_q;
    assign bus.ras_count = cnt_q;
    assign bus.ras_empty = ras_empty_w;
    assign bus.ras_full  = ras_full_w;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule
